// File: rtl/wb_initiator.sv
`timescale 1ns/1ps
// wb_initiator: Wishbone classic initiator. Turns a valid/ready command
// (address, data, byte selects, beat count) into one Wishbone cycle per
// beat and returns one response per beat on a valid/ready channel.
// Optional feature: define WB_INIT_TIMEOUT_EN to enable a bus watchdog that
// aborts a beat after TIMEOUT_CYCLES cycles without ACK.
module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic [7:0]  cmd_len,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_last;

    logic        w_accept;
    logic        w_ack;
    logic        w_tmo;
    logic        w_hs;
    logic        w_wdog_hit;

`ifdef WB_INIT_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        r_rsp_err;

    // Watchdog counts cycles spent in BUS; it sits at zero in every other
    // state, so each beat starts its count from zero on BUS entry.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wdog <= 16'd0;
        end else if (r_state != S_BUS) begin
            r_wdog <= 16'd0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    // The limit is hit on the edge ending the TIMEOUT_CYCLES-th STB cycle.
    assign w_wdog_hit = (r_wdog == 16'(TIMEOUT_CYCLES - 1));

    // Error flag is written together with the response it belongs to.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rsp_err <= 1'b0;
        end else if (w_ack) begin
            r_rsp_err <= 1'b0;
        end else if (w_tmo) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_wdog_hit = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the one-cycle event strobes that drive the datapath.
    // ACK is checked before the watchdog so an ACK on the limit edge wins.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ack    = 1'b0;
        w_tmo    = 1'b0;
        w_hs     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_BUS;
                end
            end
            S_BUS: begin
                if (wbm_ack_i) begin
                    w_ack  = 1'b1;
                    w_next = S_RESP;
                end else if (w_wdog_hit) begin
                    w_tmo  = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_hs   = 1'b1;
                    w_next = r_rsp_last ? S_IDLE : S_BUS;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command latch, beat counter and address stepping between beats.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_we   <= 1'b0;
            r_adr  <= 32'd0;
            r_dat  <= 32'd0;
            r_sel  <= 4'd0;
            r_len  <= 8'd0;
            r_beat <= 8'd0;
        end else if (w_accept) begin
            r_we   <= cmd_we;
            r_adr  <= cmd_adr;
            r_dat  <= cmd_dat;
            r_sel  <= cmd_sel;
            r_len  <= cmd_len;
            r_beat <= 8'd0;
        end else if (w_hs && !r_rsp_last) begin
            r_beat <= r_beat + 8'd1;
            r_adr  <= r_adr + 32'd4;
        end
    end

    // Response capture; held untouched for the whole RESP state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rsp_dat  <= 32'd0;
            r_rsp_last <= 1'b0;
        end else if (w_ack) begin
            r_rsp_dat  <= r_we ? 32'd0 : wbm_dat_i;
            r_rsp_last <= (r_beat == r_len);
        end else if (w_tmo) begin
            r_rsp_dat  <= 32'd0;
            r_rsp_last <= 1'b1;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign wbm_cyc_o = (r_state == S_BUS);
    assign wbm_stb_o = (r_state == S_BUS);
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_dat   = r_rsp_dat;
    assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_wb_initiator.sv
`timescale 1ns/1ps
// Testbench for wb_initiator: randomized commands against a transaction-level
// reference model, with a queue-based scoreboard checked by a monitor.
module tb_wb_initiator;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err, rsp_last;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .cmd_len  (cmd_len),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .rsp_last (rsp_last)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } bus_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    int waits = 0;
    bit hang = 1'b0;
    int stall = 0;
    bit rnd_ready = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur, expected it within bound", name);
    endfunction

    // Reference model: one bus beat and one response per beat, address
    // stepping by 4 modulo 2^32, read data defined by the slave rule.
    function automatic void model_cmd(logic we, logic [31:0] adr, logic [31:0] dat,
                                      logic [3:0] sel, logic [7:0] len);
        logic [31:0] a;
        bus_t b;
        rsp_t r;
        a = adr;
        for (int i = 0; i <= int'(len); i++) begin
            b.adr = a; b.we = we; b.dat = dat; b.sel = sel;
            bus_q.push_back(b);
            r.dat  = we ? 32'd0 : (a ^ 32'hA5A5_A5A5);
            r.err  = 1'b0;
            r.last = (i == int'(len));
            rsp_q.push_back(r);
            a = a + 32'd4;
        end
    endfunction

    // Slave: ACK after 'waits' wait states, read data = address ^ A5A5A5A5.
    initial begin
        int wcnt;
        wcnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && wbm_cyc_o && wbm_stb_o && !hang && !wbm_ack_i) begin
                if (wcnt >= waits) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = wbm_adr_o ^ 32'hA5A5_A5A5;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
                wcnt = 0;
            end
        end
    end

    // Response consumer: forced stall count, else always or randomly ready.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) stall--;
            end else begin
                rsp_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic        p_valid, p_ready, p_last, p_err, p_stb, p_ack;
        logic [31:0] p_dat;
        int          stbcnt;
        bus_t        b;
        rsp_t        r;
        p_valid = 0; p_ready = 0; p_last = 0; p_err = 0; p_stb = 0; p_ack = 0;
        p_dat = 0; stbcnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                p_valid = 0; p_ready = 0; p_last = 0; p_err = 0; p_stb = 0; p_ack = 0;
                p_dat = 0; stbcnt = 0;
                continue;
            end
            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_dat", rsp_dat, p_dat);
                chk("hold_last", 32'(rsp_last), 32'(p_last));
                chk("hold_err", 32'(rsp_err), 32'(p_err));
                chk("stall_no_stb", 32'(wbm_stb_o), 32'd0);
            end
            if (p_valid && p_ready) begin
                if (p_last) chk("ready_after_last", 32'(cmd_ready), 32'd1);
                else        chk("next_beat_stb", 32'(wbm_stb_o), 32'd1);
            end
            if (p_stb && p_ack) chk("cyc_gap_after_ack", 32'(wbm_cyc_o), 32'd0);
            if (wbm_stb_o) stbcnt++;
            if (wbm_stb_o && wbm_ack_i) begin
                if (bus_q.size() == 0) begin
                    fail("unexpected_bus_beat");
                end else begin
                    b = bus_q.pop_front();
                    chk("beat_cyc", 32'(wbm_cyc_o), 32'd1);
                    chk("beat_adr", wbm_adr_o, b.adr);
                    chk("beat_we", 32'(wbm_we_o), 32'(b.we));
                    chk("beat_dat", wbm_dat_o, b.dat);
                    chk("beat_sel", 32'(wbm_sel_o), 32'(b.sel));
                    chk("beat_stb_len", 32'(stbcnt), 32'(waits + 1));
                end
                stbcnt = 0;
            end
            if (p_stb && !p_ack && !wbm_stb_o) begin
`ifdef WB_INIT_TIMEOUT_EN
                chk("tmo_stb_len", 32'(stbcnt), 32'(TMO));
`else
                fail("stb_dropped_without_ack");
`endif
                stbcnt = 0;
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    fail("unexpected_response");
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_dat", rsp_dat, r.dat);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_last", 32'(rsp_last), 32'(r.last));
                end
            end
            p_valid = rsp_valid; p_ready = rsp_ready; p_last = rsp_last;
            p_err = rsp_err; p_dat = rsp_dat; p_stb = wbm_stb_o; p_ack = wbm_ack_i;
        end
    end

    // Present one command, wait for acceptance, then scramble the inputs.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [7:0] len);
        int b;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
        cmd_sel = sel; cmd_len = len;
        b = 0;
        while (!cmd_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) fail("cmd_accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we  = 1'($urandom);
        cmd_adr = $urandom;
        cmd_dat = $urandom;
        cmd_sel = 4'($urandom);
        cmd_len = 8'($urandom);
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [7:0] len);
        model_cmd(we, adr, dat, sel, len);
        issue(we, adr, dat, sel, len);
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while ((rsp_q.size() != 0 || !cmd_ready) && b < 4000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 4000) begin
            fail("command_completion");
            bus_q.delete();
            rsp_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("leftover_beats", 32'(bus_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation still running, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int b;
        // Reset values
        #12;
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write, 2 wait states
        waits = 2;
        send(1'b1, 32'h3000_0000, 32'h0000_0005, 4'hF, 8'd0);
        wait_done();

        // Read burst of four beats
        waits = 1;
        send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 8'd3);
        wait_done();

        // Backpressure on a 2-beat read
        waits = 0;
        stall = 5;
        send(1'b0, 32'h3000_0100, 32'h0, 4'h3, 8'd1);
        wait_done();

        // Address wrap
        waits = 0;
        send(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 8'd1);
        wait_done();

`ifdef WB_INIT_TIMEOUT_EN
        // Timeout: slave never answers, only one error response expected
        begin
            rsp_t r;
            hang = 1'b1;
            r.dat = 32'd0; r.err = 1'b1; r.last = 1'b1;
            rsp_q.push_back(r);
            issue(1'b0, 32'h3000_0200, 32'h0, 4'hF, 8'd2);
            wait_done();
            repeat (4) @(negedge clk);
            chk("tmo_no_more_stb", 32'(wbm_stb_o), 32'd0);
            hang = 1'b0;
        end
`endif

        // Reset in the middle of a beat
        waits = 8;
        issue(1'b0, 32'h1000_0000, 32'h0, 4'hF, 8'd3);
        b = 0;
        while (!wbm_stb_o && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (b >= 20) fail("stb_before_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("arst_stb", 32'(wbm_stb_o), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        bus_q.delete();
        rsp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        waits = 1;
        send(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'h5, 8'd1);
        wait_done();

        // Randomized commands with random backpressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            logic        we;
            logic [31:0] adr;
            we  = 1'($urandom);
            adr = {$urandom} & 32'hFFFF_FFFC;
            if (n % 6 == 0) adr = 32'hFFFF_FFF0;
            waits = $urandom_range(0, 3);
            send(we, adr, $urandom, 4'($urandom), 8'($urandom_range(0, 7)));
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic initiator that turns a simple valid/ready command interface into single or repeated Wishbone read/write cycles, and returns one response per beat. It is the bus-master counterpart of the team's Wishbone-slave user projects. It sits between a command source (logic analyzer or on-chip sequencer) and a Wishbone slave port, and drives `wbs_*`-style slave inputs directly.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles STB may stay high without ACK (used only with `WB_INIT_TIMEOUT_EN`), range 1..65535.
- `wb_clk_i` in 1: the block's one clock; all logic on the rising edge.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in 32: first beat byte address.
- `cmd_dat` in 32: write data, used for every write beat.
- `cmd_sel` in 4: byte selects, used for every beat.
- `cmd_len` in 8: number of beats minus 1 (0..255 means 1..256 beats).
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone cycle, strobe and write enable.
- `wbm_sel_o` out 4: Wishbone byte selects.
- `wbm_adr_o` out 32: Wishbone address.
- `wbm_dat_o` out 32: Wishbone write data.
- `wbm_ack_i` in 1: slave acknowledge.
- `wbm_dat_i` in 32: slave read data.
- `rsp_valid` out 1: beat response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_dat` out 32: read data captured on ACK; 0 for writes.
- `rsp_err` out 1: the beat timed out.
- `rsp_last` out 1: final response of the command.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE
  - `cmd_ready`=1.
  - When `cmd_valid` is 1, latch we/adr/dat/sel/len, clear the beat counter, and go to BUS.
- BUS
  - `wbm_cyc_o`=`wbm_stb_o`=1 and all other `wbm_*` outputs stable.
  - When `wbm_ack_i`=1: capture `wbm_dat_i` (reads only, otherwise 0) into `rsp_dat`, set `rsp_err`=0, and go to RESP.
- RESP
  - `rsp_valid`=1, and `wbm_cyc_o`=`wbm_stb_o`=0.
  - `rsp_last` = (beat counter == len) OR `rsp_err`.
  - When `rsp_ready`=1: if last, go to IDLE; otherwise increment the counter, set address += 4, and go to BUS.
- Address arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- `wbm_ack_i` is ignored outside BUS.
- There is never more than one outstanding beat.
- `cmd_valid` is ignored outside IDLE. The latched command is unaffected by input changes after acceptance.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All `wbm_*` outputs, `rsp_valid`, `rsp_dat`, `rsp_err`, `rsp_last` and the counters go to 0.
  - `cmd_ready` is 1 after release.
  - A reset during BUS abandons the cycle with no response.

## Timing
- All outputs are registered; no combinational path from input to output.
- Command accepted at edge T → CYC/STB high from T+1.
- ACK sampled at edge T+1+k (k ≥ 0 wait states) → CYC/STB low and `rsp_valid` high from T+2+k.
- Write beat latency from acceptance to response: 2+k cycles.
- Between beats, CYC/STB are low for at least one cycle (the RESP cycle), so a single-cycle ACK from the slave is never double-counted.
- `rsp_*` outputs are held stable while `rsp_valid`=1 and `rsp_ready`=0.
- Next beat STB rises the cycle after the `rsp_ready` handshake.
- The cycle after a last-response handshake, `cmd_ready`=1; the next command can be accepted that same cycle.

## Configuration
- Macro `WB_INIT_TIMEOUT_EN`.
- Defined:
  - A 16-bit watchdog counts cycles spent in BUS; it is cleared on BUS entry.
  - If the count reaches `TIMEOUT_CYCLES` without ACK, drop CYC/STB and go to RESP with `rsp_err`=1, `rsp_dat`=0, `rsp_last`=1. Remaining beats are skipped.
  - STB is high for exactly `TIMEOUT_CYCLES` cycles before the abort.
  - ACK arriving on the same edge the count reaches the limit wins: normal response, `rsp_err`=0.
- Undefined:
  - No watchdog; BUS waits indefinitely.
  - `rsp_err` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Test plan
- Single write:
  - Stimulus: `cmd_adr`=0x3000_0000, `cmd_dat`=0x0000_0005, sel=0xF, we=1, len=0; slave ACKs with 2 wait states.
  - Required: CYC/STB/WE high for 3 cycles with adr/dat/sel matching the command, then `rsp_valid`=1, `rsp_err`=0, `rsp_last`=1, `rsp_dat`=0.
- Read burst:
  - Stimulus: adr 0x3000_0000, len=3, slave returns adr^0xA5A5_A5A5.
  - Required: four STB phases at 0x…00, 04, 08, 0C; four responses with matching data; `rsp_last` set only on the 4th; CYC low between beats.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles during a 2-beat read.
  - Required: no STB while stalled; `rsp_dat` and `rsp_last` stable; second beat STB starts the cycle after the handshake.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16):
  - Stimulus: slave never ACKs, len=2.
  - Required: STB high exactly 16 cycles, then a single response with `rsp_err`=1, `rsp_last`=1; return to IDLE; no further beats.
- Reset mid-beat:
  - Stimulus: drop `wb_rst_ni` while STB is high.
  - Required: CYC/STB/`rsp_valid` go to 0 without waiting for a clock edge; after release, `cmd_ready`=1 and a new command completes normally.
- Address wrap:
  - Stimulus: adr 0xFFFF_FFFC, len=1, read.
  - Required: beat addresses 0xFFFF_FFFC then 0x0000_0000.
